ef_dacn_stream_ctrl: RTL and testbench

//  Multi-channel, parametrised-width DAC streaming controller. Buffers frames in a FIFO; one frame
//  is NCH samples written as one word. Frames are popped at a programmable sample rate and driven

---
 rtl/ef_dac_pkg.sv | 23 ++
 rtl/ef_dac_frame_fifo.sv | 71 +++++++
 rtl/ef_dacn_stream_ctrl.sv | 171 +++++++++++++++++
 tb/tb_ef_dacn_stream_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/ef_dac_pkg.sv
// Shared types and constants for the multi-channel DAC streaming controller.
//   ctrl_state_t : controller FSM states (IDLE, PRIME, RUN)
//   dac_mode_t   : output behaviour on underflow (HOLD last frame / MIDSCALE)
//   midscale()   : mid-range code for a DAC of a given resolution
package ef_dac_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } ctrl_state_t;

  typedef enum logic {
    HOLD     = 1'b0,
    MIDSCALE = 1'b1
  } dac_mode_t;

  // Mid-range code 1<<(dw-1); callers narrow it to their own channel width.
  function automatic int unsigned midscale(input int unsigned dw);
    return 32'd1 << (dw - 32'd1);
  endfunction

endpackage

// File: rtl/ef_dac_frame_fifo.sv
// Frame FIFO with fall-through read for the DAC streaming controller.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (pointers and level only)
//   flush      : synchronous clear of pointers/level; a same-cycle write is discarded
//   wr, wdata  : push one frame
//   rd         : pop the head frame (ignored while empty)
//   rdata      : head frame, valid whenever !empty
//   level      : frames held, 0..2**AW
//   empty/full : status
//   wr_drop    : a write was refused because the FIFO was full and nothing was popped
module ef_dac_frame_fifo #(
  parameter int DW = 20,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          wr,
  input  logic [DW-1:0] wdata,
  input  logic          rd,
  output logic [DW-1:0] rdata,
  output logic [AW:0]   level,
  output logic          empty,
  output logic          full,
  output logic          wr_drop
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          rd_ok;
  logic          wr_ok;

  assign empty = (level == '0);
  assign full  = (level == (AW+1)'(DEPTH));
  assign rd_ok = rd & ~empty;
  // When full, a pop in the same cycle frees the slot the write lands in;
  // wptr == rptr then, and the read sees the old word before the edge.
  assign wr_ok   = wr & ~flush & (~full | rd_ok);
  assign wr_drop = wr & ~flush & full & ~rd_ok;
  assign rdata   = mem[rptr];

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wptr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (wr_ok) wptr <= wptr + 1'b1;
      if (rd_ok) rptr <= rptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/ef_dacn_stream_ctrl.sv
// Multi-channel DAC streaming controller.
// Frames (NCH samples of DW bits, channel c in [c*DW +: DW]) are buffered in a
// FIFO, pre-filled up to fifo_threshold, then popped at one frame every
// clkdiv+1 enabled cycles and registered onto dac_sel.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   en              : controller/DAC enable (drop returns to IDLE)
//   clk_en          : divider run enable, pauses the sample cadence in RUN
//   clkdiv          : sample period minus one
//   fifo_threshold  : low watermark and pre-fill level
//   mode            : underflow behaviour, 0 = HOLD, 1 = MIDSCALE
//   flush           : clears the FIFO, RUN/PRIME fall back to PRIME
//   clr_flags       : clears sticky underflow/overflow (a new set wins)
//   wr, wdata       : push one frame
//   level/empty/full/low : FIFO status
//   underflow/overflow   : sticky error flags
//   update          : one-cycle pulse when dac_sel takes a new source frame
//   DAC_EN, DAC_RST : DAC control straps
//   dac_sel         : registered DAC codes
module ef_dacn_stream_ctrl
  import ef_dac_pkg::*;
#(
  parameter int DW      = 10,
  parameter int NCH     = 2,
  parameter int FIFO_AW = 5,
  parameter int DIV_W   = 20
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                clk_en,
  input  logic [DIV_W-1:0]    clkdiv,
  input  logic [FIFO_AW:0]    fifo_threshold,
  input  logic                mode,
  input  logic                flush,
  input  logic                clr_flags,
  input  logic                wr,
  input  logic [NCH*DW-1:0]   wdata,
  output logic [FIFO_AW:0]    level,
  output logic                empty,
  output logic                full,
  output logic                low,
  output logic                underflow,
  output logic                overflow,
  output logic                update,
  output logic                DAC_EN,
  output logic                DAC_RST,
  output logic [NCH*DW-1:0]   dac_sel
);

  localparam int FW = NCH * DW;
  localparam logic [DW-1:0] MID = DW'(midscale(DW));

  ctrl_state_t      state;
  ctrl_state_t      state_nxt;
  dac_mode_t        mode_e;
  logic [DIV_W-1:0] cnt;
  logic [FW-1:0]    fifo_rdata;
  logic [FW-1:0]    mid_frame;
  logic             wr_drop;
  logic             in_run;
  logic             tick;
  logic             pop;
  logic             starve;

  assign mode_e  = dac_mode_t'(mode);
  assign DAC_EN  = en;
  assign DAC_RST = ~rst_n;
  assign low     = (level < fifo_threshold);

  ef_dac_frame_fifo #(
    .DW (FW),
    .AW (FIFO_AW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .wr      (wr),
    .wdata   (wdata),
    .rd      (pop),
    .rdata   (fifo_rdata),
    .level   (level),
    .empty   (empty),
    .full    (full),
    .wr_drop (wr_drop)
  );

  always_comb begin
    mid_frame = '0;
    for (int c = 0; c < NCH; c++) begin
      mid_frame[c*DW +: DW] = MID;
    end
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM: next state. A threshold of 0 makes low=0, so PRIME leaves next cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (en) state_nxt = PRIME;
      end
      PRIME: begin
        if (!en)                state_nxt = IDLE;
        else if (flush)         state_nxt = PRIME;
        else if (!low || full)  state_nxt = RUN;
      end
      RUN: begin
        if (!en)        state_nxt = IDLE;
        else if (flush) state_nxt = PRIME;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM: outputs. Underflow stays in RUN; the next written frame is simply
  // picked up on a later tick.
  always_comb begin
    in_run = (state == RUN);
    tick   = in_run & clk_en & (cnt == clkdiv);
    pop    = tick & ~empty;
    starve = tick & empty;
  end

  // Sample divider. An equality compare only: lowering clkdiv below cnt lets
  // cnt run on to the natural 2**DIV_W wrap before the next tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!in_run) begin
      cnt <= '0;
    end else if (clk_en) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

  // Output register: one cycle from tick to the new code on dac_sel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dac_sel <= '0;
      update  <= 1'b0;
    end else if (pop) begin
      dac_sel <= fifo_rdata;
      update  <= 1'b1;
    end else if (starve && mode_e == MIDSCALE) begin
      dac_sel <= mid_frame;
      update  <= 1'b1;
    end else begin
      update  <= 1'b0;
    end
  end

  // Sticky flags; a set in the same cycle beats clr_flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underflow <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (starve)         underflow <= 1'b1;
      else if (clr_flags) underflow <= 1'b0;
      if (wr_drop)        overflow  <= 1'b1;
      else if (clr_flags) overflow  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ef_dacn_stream_ctrl.sv
// Scoreboard bench for ef_dacn_stream_ctrl (DW=10, NCH=4, depth 32).
// A driver applies inputs on the falling edge, advances a queue-based
// reference model and pushes the expected post-edge snapshot; a monitor pops
// one snapshot per rising edge and compares it with the DUT outputs.
module tb_ef_dacn_stream_ctrl;

  localparam int DW    = 10;
  localparam int NCH   = 4;
  localparam int AW    = 5;
  localparam int DIV_W = 20;
  localparam int FW    = NCH * DW;
  localparam int DEPTH = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en, clk_en, mode, flush, clr_flags, wr;
  logic [DIV_W-1:0] clkdiv;
  logic [AW:0]      thr;
  logic [FW-1:0]    wdata;
  logic [AW:0]      level;
  logic             empty, full, low, underflow, overflow, update, DAC_EN, DAC_RST;
  logic [FW-1:0]    dac_sel;

  ef_dacn_stream_ctrl #(.DW(DW), .NCH(NCH), .FIFO_AW(AW), .DIV_W(DIV_W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clk_en(clk_en), .clkdiv(clkdiv),
    .fifo_threshold(thr), .mode(mode), .flush(flush), .clr_flags(clr_flags),
    .wr(wr), .wdata(wdata), .level(level), .empty(empty), .full(full), .low(low),
    .underflow(underflow), .overflow(overflow), .update(update), .DAC_EN(DAC_EN),
    .DAC_RST(DAC_RST), .dac_sel(dac_sel)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            lvl;
    bit            lo, uf, of, upd, en_e;
    logic [FW-1:0] sel;
  } snap_t;

  snap_t         sq[$];
  snap_t         ms;
  int            checks = 0;
  int            failures = 0;
  bit            chk_on = 1'b0;

  // reference model: 0 = waiting for enable, 1 = pre-filling, 2 = streaming
  int            m_st;
  logic [FW-1:0] m_q[$];
  int unsigned   m_cnt;
  logic [FW-1:0] m_sel;
  bit            m_upd, m_uf, m_of;
  logic [FW-1:0] mid;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit m_tick();
    return (m_st == 2) && clk_en && (m_cnt == 32'(clkdiv));
  endfunction

  task automatic model_reset();
    m_st = 0; m_q.delete(); m_cnt = 0; m_sel = '0; m_upd = 0; m_uf = 0; m_of = 0;
  endtask

  task automatic model_step();
    bit tk, emp, ful, pop, drop, lo;
    logic [FW-1:0] head;
    int nst;
    snap_t s;
    tk   = m_tick();
    emp  = (m_q.size() == 0);
    ful  = (m_q.size() == DEPTH);
    pop  = tk && !emp;
    head = emp ? '0 : m_q[0];
    lo   = m_q.size() < int'(thr);
    nst  = m_st;
    if (!en)                             nst = 0;
    else if (m_st == 0 || flush)         nst = 1;
    else if (m_st == 1 && (!lo || ful))  nst = 2;
    drop = 0;
    if (flush) m_q.delete();
    else begin
      drop = wr && ful && !pop;
      if (pop) void'(m_q.pop_front());
      if (wr && !drop) m_q.push_back(wdata);
    end
    if (pop)                     begin m_sel = head; m_upd = 1; end
    else if (tk && emp && mode)  begin m_sel = mid;  m_upd = 1; end
    else                         m_upd = 0;
    if (tk && emp)   m_uf = 1; else if (clr_flags) m_uf = 0;
    if (drop)        m_of = 1; else if (clr_flags) m_of = 0;
    if (m_st != 2)   m_cnt = 0;
    else if (clk_en) m_cnt = tk ? 0 : (m_cnt + 1) % (32'd1 << DIV_W);
    m_st = nst;
    s.lvl = m_q.size(); s.lo = (m_q.size() < int'(thr)); s.uf = m_uf; s.of = m_of;
    s.upd = m_upd; s.sel = m_sel; s.en_e = en;
    sq.push_back(s);
  endtask

  task automatic cyc(input bit w, input bit f, input bit c);
    wr = w; flush = f; clr_flags = c;
    wdata = FW'({$urandom(), $urandom()});
    model_step();
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_level"}, 64'(level), 64'd0);
    chk({tag, "_empty"}, 64'(empty), 64'd1);
    chk({tag, "_full"}, 64'(full), 64'd0);
    chk({tag, "_update"}, 64'(update), 64'd0);
    chk({tag, "_underflow"}, 64'(underflow), 64'd0);
    chk({tag, "_overflow"}, 64'(overflow), 64'd0);
    chk({tag, "_dac_sel"}, 64'(dac_sel), 64'd0);
    chk({tag, "_dac_rst"}, 64'(DAC_RST), 64'd1);
  endtask

  // monitor: one expected snapshot per rising edge
  always @(posedge clk) begin
    if (chk_on) begin
      #1;
      if (sq.size() == 0) begin
        checks++; failures++;
        $display("FAIL sb_underrun got=0 exp=1 entries at %0t", $time);
      end else begin
        ms = sq.pop_front();
        chk("level", 64'(level), 64'(ms.lvl));
        chk("empty", 64'(empty), 64'(ms.lvl == 0));
        chk("full", 64'(full), 64'(ms.lvl == DEPTH));
        chk("low", 64'(low), 64'(ms.lo));
        chk("underflow", 64'(underflow), 64'(ms.uf));
        chk("overflow", 64'(overflow), 64'(ms.of));
        chk("update", 64'(update), 64'(ms.upd));
        chk("dac_en", 64'(DAC_EN), 64'(ms.en_e));
        chk("dac_rst", 64'(DAC_RST), 64'd0);
        for (int c = 0; c < NCH; c++)
          chk($sformatf("dac_sel_ch%0d", c), 64'(dac_sel[c*DW +: DW]), 64'(ms.sel[c*DW +: DW]));
      end
    end
  end

  initial begin
    for (int c = 0; c < NCH; c++) mid[c*DW +: DW] = 10'h200;
    rst_n = 1'b0; en = 0; clk_en = 1; mode = 0; flush = 0; clr_flags = 0; wr = 0;
    clkdiv = DIV_W'(3); thr = (AW+1)'(4); wdata = '0;
    @(negedge clk); @(negedge clk);
    check_reset_outputs("por");
    rst_n = 1'b1;
    model_reset();
    chk_on = 1'b1;

    // startup: pre-fill 4 frames, then one frame every 4 cycles
    en = 1;
    for (int i = 0; i < 4; i++) cyc(1, 0, 0);
    for (int i = 0; i < 24; i++) cyc(0, 0, 0);

    // drained: HOLD underflow, then MIDSCALE underflow
    cyc(0, 0, 1);
    mode = 1;
    for (int i = 0; i < 12; i++) cyc(0, 0, 0);

    // fill to full, overflow, then write exactly on pop ticks while full
    clkdiv = DIV_W'(40); mode = 0;
    cyc(0, 1, 1);
    for (int i = 0; i < DEPTH; i++) cyc(1, 0, 0);
    cyc(1, 0, 0);
    cyc(0, 0, 1);
    for (int i = 0; i < 90; i++) cyc(m_tick(), 0, 0);

    // pop every cycle
    clkdiv = '0; thr = (AW+1)'(8);
    cyc(0, 1, 1);
    for (int i = 0; i < 60; i++) cyc(($urandom_range(0, 3) != 0), 0, 0);

    // flush at level 10 with a discarded write, then clear against new underflows
    clkdiv = DIV_W'(7); thr = (AW+1)'(4);
    cyc(0, 1, 1);
    for (int i = 0; i < 40 && m_q.size() != 10; i++) cyc(1, 0, 0);
    chk("prefill_level10", 64'(level), 64'd10);
    cyc(1, 1, 0);
    thr = '0; mode = 1;
    for (int i = 0; i < 30; i++) cyc(0, 0, 1);

    // random streaming with clk_en gaps
    clkdiv = DIV_W'(2); thr = (AW+1)'(3); mode = 0;
    cyc(0, 1, 1);
    for (int i = 0; i < 200; i++) begin
      clk_en = ($urandom_range(0, 3) != 0);
      mode   = (i >= 100);
      cyc($urandom_range(0, 1) == 1, 0, $urandom_range(0, 15) == 0);
    end

    // asynchronous reset pulse between edges
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_rst");
    model_reset();
    #1 rst_n = 1'b1;
    clk_en = 1;
    for (int i = 0; i < 30; i++) cyc($urandom_range(0, 1) == 1, 0, 0);

    // enable drop mid-stream, then restart
    en = 0;
    for (int i = 0; i < 5; i++) cyc(0, 0, 0);
    en = 1;
    for (int i = 0; i < 40; i++) cyc($urandom_range(0, 2) == 0, 0, 0);

    chk("sb_drain", 64'(sq.size()), 64'd0);
    chk_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
